rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter that shares a single 8-way resource (for example a decoded register-file write port or bus select line) among eight requesters. Each cycle it produces a registered one-hot grant vector and its 3-bit index, so downstream logic receives a clean select code plus enable. A hold-time limit forces release from a requester that keeps its request asserted too long. A mandatory one-cycle turnaround separates consecutive grants.

## Interface
- HOLD_MAX, default 15: maximum consecutive cycles one grant may be held. Legal range is 1..255.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request level, one bit per requester; bit i is held high while requester i wants or owns the resource.
- gnt  out  8  one-hot grant, or all zeros when nothing is granted.
- gnt_id  out  3  index of the granted requester; valid only while gnt_valid=1.
- gnt_valid  out  1  high whenever gnt is nonzero; this is the enable to the select decoder.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- **States:** IDLE, GRANT, GAP (2-bit encoding).
- **Registers:** ptr[2:0] (last granted index), hold_cnt[7:0], plus the output registers. All outputs are registered.
- **Reset values:** state=IDLE, ptr=7, hold_cnt=0, gnt=8'h00, gnt_id=0, gnt_valid=0, timeout=0. Because ptr resets to 7, requester 0 has top priority after reset.
- **Arbitration function:** select the first i with req[i]=1, searching (ptr+1) mod 8 upward and wrapping through ptr. The previous owner therefore has lowest priority.
- **IDLE:**
  - If req != 0: load the selected index into gnt_id and ptr. Set gnt to the decoded one-hot of that index, gnt_valid=1, hold_cnt=0, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT:** evaluated every edge, in this priority order.
  1. req[gnt_id]=0 (voluntary release): gnt=0, gnt_valid=0, go to GAP.
  2. hold_cnt == HOLD_MAX-1 (forced release): gnt=0, gnt_valid=0, timeout=1 for the next cycle only, go to GAP.
  3. Otherwise: hold_cnt increments.
  - Changes on requests other than req[gnt_id] are ignored while in GRANT. There is no preemption.
- **GAP:** outputs remain deasserted for exactly one cycle.
  - If req != 0: arbitrate exactly as in IDLE and go to GRANT.
  - Otherwise go to IDLE.
- **Timed-out requester:** it stays eligible for a new grant. It gets one only through normal rotation, so if it is the sole requester it is regranted after the GAP cycle.
- **Invariants:** gnt is always 0 or one-hot; gnt == (1 << gnt_id) whenever gnt_valid=1; timeout is never high in two consecutive cycles.
- **Reset mid-grant:** all outputs drop immediately, asynchronously. After rst deasserts, arbitration restarts from ptr=7.

## Timing
- **Grant latency:**
  - From IDLE: req is sampled at edge k; gnt is visible after edge k, so it is usable in cycle k+1.
- **Release latency:** req[gnt_id] low is sampled at edge k; gnt is 0 after edge k.
- **Grant-to-grant gap:** minimum 1 cycle with gnt_valid=0 (the GAP state).
- **Maximum hold:** gnt_valid is high for at most HOLD_MAX consecutive cycles.
- **Timeout alignment:** timeout is high in the first GAP cycle, coincident with gnt=0.
- **Boundary cases:**
  - HOLD_MAX=1: every grant lasts exactly one cycle. timeout pulses after every grant whose req stays high.
  - Request rising during the GAP cycle: it is arbitrated at the GAP exit edge.
  - Wrap-around: with ptr=7, index 0 is checked first.

## Test plan
- **Reset values:** assert rst mid-grant with req=8'hFF. Required: gnt=0, gnt_valid=0, timeout=0 immediately. After release, the first grant goes to index 0.
- **Single requester:** req=8'h10 held for 3 cycles, then dropped. Required: gnt=8'h10 and gnt_id=4 for 3 cycles, then 0. The next cycle returns to IDLE.
- **Full rotation:** req=8'hFF, each owner holding 2 cycles then dropping for one cycle. Required grant order: 0,1,…,7,0 with a 1-cycle gap between grants.
- **Timeout:** HOLD_MAX=4, req=8'h01 held continuously. Required: gnt high for exactly 4 cycles, then timeout=1 for 1 cycle with gnt=0, then regrant of index 0. This repeats.
- **Fairness after timeout:** HOLD_MAX=4, req=8'h81 held continuously. Required: grants alternate 0,7,0,7. timeout pulses after each grant.
- **Invariant monitor:** random req for 10k cycles. Required checks:
  - gnt is one-hot or zero.
  - gnt == 1<<gnt_id whenever gnt_valid=1.
  - No grant lasts longer than HOLD_MAX cycles.
  - No back-to-back grants without a gap.
  - No requester held high waits more than 7 grants.

Source files
------------

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with registered one-hot grant,
// grant index, hold-time limit with forced release, and a mandatory one-cycle
// turnaround between consecutive grants.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grant outstanding, waiting for any request
// GRANT | gnt/gnt_id/gnt_valid drive the current owner, hold_cnt is counting
// GAP   | one-cycle turnaround after a release; outputs deasserted
module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Terminal count of the hold timer: the grant is revoked on the edge
    // where hold_cnt reaches this value with the owner still requesting.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [7:0] hold_cnt, hold_cnt_n;
    logic [7:0] gnt_n;
    logic [2:0] gnt_id_n;
    logic       gnt_valid_n;
    logic       timeout_n;

    logic       arb_found;
    logic [2:0] arb_idx;
    logic [2:0] cand;

    // Rotating priority search: start just after the last owner and wrap
    // around so that the last owner itself is checked last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = ptr;
        cand      = ptr;
        for (int k = 1; k <= 8; k++) begin
            cand = ptr + 3'(k);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic; timeout defaults low so it can only
    // ever be a single-cycle pulse.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        hold_cnt_n  = hold_cnt;
        gnt_n       = gnt;
        gnt_id_n    = gnt_id;
        gnt_valid_n = gnt_valid;
        timeout_n   = 1'b0;

        case (state)
            IDLE, GAP: begin
                gnt_n       = 8'h00;
                gnt_valid_n = 1'b0;
                if (arb_found) begin
                    ptr_n       = arb_idx;
                    gnt_id_n    = arb_idx;
                    gnt_n       = 8'h01 << arb_idx;
                    gnt_valid_n = 1'b1;
                    hold_cnt_n  = 8'h00;
                    state_n     = GRANT;
                end else begin
                    state_n = IDLE;
                end
            end

            GRANT: begin
                if (!req[gnt_id]) begin
                    gnt_n       = 8'h00;
                    gnt_valid_n = 1'b0;
                    state_n     = GAP;
                end else if (hold_cnt == HOLD_LAST) begin
                    gnt_n       = 8'h00;
                    gnt_valid_n = 1'b0;
                    timeout_n   = 1'b1;
                    state_n     = GAP;
                end else begin
                    hold_cnt_n = hold_cnt + 8'd1;
                end
            end

            default: begin
                gnt_n       = 8'h00;
                gnt_valid_n = 1'b0;
                state_n     = IDLE;
            end
        endcase
    end

    // State, pointer, timer and output registers; reset clears outputs at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd7;
            hold_cnt  <= 8'h00;
            gnt       <= 8'h00;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_cnt_n;
            gnt       <= gnt_n;
            gnt_id    <= gnt_id_n;
            gnt_valid <= gnt_valid_n;
            timeout   <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and random-monitor bench for rr_arbiter8 (HOLD_MAX=4 main
// instance, HOLD_MAX=1 companion instance on the same request lines).
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;

    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    logic [7:0] gnt1;
    logic [2:0] gnt_id1;
    logic       gnt_valid1;
    logic       timeout1;

    int checks;
    int errors;

    rr_arbiter8 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    rr_arbiter8 #(.HOLD_MAX(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt1),
        .gnt_id    (gnt_id1),
        .gnt_valid (gnt_valid1),
        .timeout   (timeout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] oh;
    logic [7:0] req_at_edge;
    logic [7:0] prev_gnt;
    logic       prev_valid;
    logic       prev_to;
    logic       new_grant;
    int         run;
    int         waitc [8];
    int         n;
    int         id;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = 8'h00;
        tick();
        tick();

        // Reset values
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_gnt_id", {5'd0, gnt_id}, 8'd0);
        chk("rst_valid", {7'd0, gnt_valid}, 8'd0);
        chk("rst_timeout", {7'd0, timeout}, 8'd0);
        rst = 1'b0;

        // First grant after reset goes to index 0, then reset mid-grant
        req = 8'hFF;
        tick();
        chk("first_gnt", gnt, 8'h01);
        chk("first_id", {5'd0, gnt_id}, 8'd0);
        chk("first_valid", {7'd0, gnt_valid}, 8'd1);
        tick();
        chk("first_hold", gnt, 8'h01);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_gnt", gnt, 8'h00);
        chk("async_rst_valid", {7'd0, gnt_valid}, 8'd0);
        chk("async_rst_timeout", {7'd0, timeout}, 8'd0);
        #2 rst = 1'b0;
        tick();
        chk("post_rst_gnt", gnt, 8'h01);
        chk("post_rst_id", {5'd0, gnt_id}, 8'd0);
        req = 8'h00;
        tick();
        chk("post_rst_release", {7'd0, gnt_valid}, 8'd0);
        tick();
        chk("post_rst_idle", {7'd0, gnt_valid}, 8'd0);

        // Single requester held 3 cycles
        req = 8'h10;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("single_gnt", gnt, 8'h10);
            chk("single_id", {5'd0, gnt_id}, 8'd4);
            chk("single_valid", {7'd0, gnt_valid}, 8'd1);
            if (c < 2) tick();
        end
        req = 8'h00;
        tick();
        chk("single_release_gnt", gnt, 8'h00);
        chk("single_release_to", {7'd0, timeout}, 8'd0);
        tick();
        chk("single_idle", {7'd0, gnt_valid}, 8'd0);

        // Full rotation 0..7,0 with one-cycle gaps
        do_reset();
        req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            id = k % 8;
            oh = 8'h01 << id;
            chk("rot_gnt", gnt, oh);
            chk("rot_id", {5'd0, gnt_id}, 8'(id));
            tick();
            chk("rot_hold", gnt, oh);
            req = 8'hFF & ~oh;
            tick();
            chk("rot_gap", {7'd0, gnt_valid}, 8'd0);
            chk("rot_gap_gnt", gnt, 8'h00);
            req = 8'hFF;
            tick();
        end
        req = 8'h00;
        tick();
        tick();

        // Timeout with HOLD_MAX=4; HOLD_MAX=1 instance alternates each cycle
        do_reset();
        req = 8'h01;
        tick();
        n = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                chk("to_gnt", gnt, 8'h01);
                chk("to_quiet", {7'd0, timeout}, 8'd0);
                chk("h1_gnt", gnt1, (n % 2 == 0) ? 8'h01 : 8'h00);
                chk("h1_timeout", {7'd0, timeout1}, 8'(n % 2));
                tick();
                n++;
            end
            chk("to_gap_gnt", gnt, 8'h00);
            chk("to_gap_valid", {7'd0, gnt_valid}, 8'd0);
            chk("to_pulse", {7'd0, timeout}, 8'd1);
            chk("h1_gnt", gnt1, (n % 2 == 0) ? 8'h01 : 8'h00);
            chk("h1_timeout", {7'd0, timeout1}, 8'(n % 2));
            tick();
            n++;
        end

        // Fairness after timeout: 0,7,0,7
        do_reset();
        req = 8'h81;
        tick();
        for (int r = 0; r < 4; r++) begin
            id = (r % 2 == 0) ? 0 : 7;
            for (int c = 0; c < 4; c++) begin
                chk("fair_id", {5'd0, gnt_id}, 8'(id));
                chk("fair_gnt", gnt, 8'h01 << id);
                chk("fair_quiet", {7'd0, timeout}, 8'd0);
                tick();
            end
            chk("fair_gap", {7'd0, gnt_valid}, 8'd0);
            chk("fair_pulse", {7'd0, timeout}, 8'd1);
            tick();
        end

        // Random invariant monitor
        do_reset();
        prev_valid = 1'b0;
        prev_gnt   = 8'h00;
        prev_to    = 1'b0;
        run        = 0;
        for (int i = 0; i < 8; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            req_at_edge = req;
            tick();
            chk("inv_onehot", {7'd0, ((gnt & (gnt - 8'd1)) == 8'd0)}, 8'd1);
            chk("inv_valid", {7'd0, gnt_valid}, {7'd0, (gnt != 8'h00)});
            if (gnt_valid) chk("inv_id_map", gnt, 8'h01 << gnt_id);
            run = gnt_valid ? run + 1 : 0;
            chk("inv_hold_max", {7'd0, (run <= 4)}, 8'd1);
            if (prev_valid && gnt_valid) chk("inv_no_b2b", gnt, prev_gnt);
            chk("inv_to_pulse", {7'd0, (prev_to && timeout)}, 8'd0);
            new_grant = gnt_valid && !prev_valid;
            for (int i = 0; i < 8; i++) begin
                if (!req_at_edge[i]) waitc[i] = 0;
                else if (new_grant && (int'(gnt_id) == i)) waitc[i] = 0;
                else if (new_grant) waitc[i] = waitc[i] + 1;
                chk("inv_starve", {7'd0, (waitc[i] <= 7)}, 8'd1);
            end
            prev_valid = gnt_valid;
            prev_gnt   = gnt;
            prev_to    = timeout;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
